// File: rtl/seq_pkg.sv
// Shared types, constants and instruction-classification helpers for the
// Y86-64 sequential stage controller.
package seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_PCUPD     = 3'd6,
        S_HALT      = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        STAT_AOK = 3'd1,
        STAT_HLT = 3'd2,
        STAT_ADR = 3'd3,
        STAT_INS = 3'd4
    } stat_t;

    localparam logic [3:0] IC_HALT   = 4'h0;
    localparam logic [3:0] IC_NOP    = 4'h1;
    localparam logic [3:0] IC_CMOVXX = 4'h2;
    localparam logic [3:0] IC_IRMOVQ = 4'h3;
    localparam logic [3:0] IC_RMMOVQ = 4'h4;
    localparam logic [3:0] IC_MRMOVQ = 4'h5;
    localparam logic [3:0] IC_OPQ    = 4'h6;
    localparam logic [3:0] IC_JXX    = 4'h7;
    localparam logic [3:0] IC_CALL   = 4'h8;
    localparam logic [3:0] IC_RET    = 4'h9;
    localparam logic [3:0] IC_PUSHQ  = 4'hA;
    localparam logic [3:0] IC_POPQ   = 4'hB;

    function automatic logic needs_mem(input logic [3:0] ic);
        case (ic)
            IC_RMMOVQ, IC_MRMOVQ, IC_CALL,
            IC_RET, IC_PUSHQ, IC_POPQ:     return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

    function automatic logic needs_wb(input logic [3:0] ic);
        case (ic)
            IC_CMOVXX, IC_IRMOVQ, IC_OPQ:  return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

    // Only instructions with a defined function field are constrained here.
    function automatic logic ifun_legal(input logic [3:0] ic, input logic [3:0] fn);
        case (ic)
            IC_CMOVXX, IC_JXX:             return fn <= 4'd6;
            IC_OPQ:                        return fn <= 4'd3;
            IC_NOP, IC_IRMOVQ, IC_RMMOVQ:  return fn == 4'd0;
            default:                       return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/seq_mem_watchdog.sv
// Counts consecutive cycles a memory request is held and pulses expired in
// the MEM_TIMEOUT-th cycle without an acknowledge.
module seq_mem_watchdog #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    output logic expired
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(MEM_TIMEOUT);

    logic [CW-1:0] cnt_reg;

    // Saturating past the last cycle keeps expired a single-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (!req) begin
            cnt_reg <= '0;
        end else if (cnt_reg != CNT_MAX) begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

    assign expired = req && (cnt_reg == CNT_LAST);

endmodule

// File: rtl/seq_stage_ctrl.sv
// Multi-cycle stage sequencer for the Y86-64 sequential processor: walks the
// datapath through its stages, handles memory handshakes and reports status.
module seq_stage_ctrl
    import seq_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  icode,
    input  logic [3:0]  ifun,
    input  logic        imem_ack,
    input  logic        imem_error,
    input  logic        dmem_ack,
    input  logic        dmem_error,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        decode_en,
    output logic        execute_en,
    output logic        wb_en,
    output logic        pc_en,
    output logic [2:0]  stat,
    output logic        busy,
    output logic [31:0] retired
);

    state_t      state_reg, state_next;
    stat_t       stat_reg, stat_next;
    logic [3:0]  icode_reg;
    logic [31:0] retired_reg;
    logic        wd_expired;

    seq_mem_watchdog #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (imem_req | dmem_req),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            stat_reg  <= STAT_AOK;
        end else begin
            state_reg <= state_next;
            stat_reg  <= stat_next;
        end
    end

    // ifun is fully consumed by the legality check in DECODE, so only icode
    // needs to survive into the later stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            icode_reg <= 4'h0;
        end else if (state_reg == S_DECODE) begin
            icode_reg <= icode;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_reg <= 32'd0;
        end else if (state_reg == S_PCUPD && retired_reg != 32'hFFFF_FFFF) begin
            retired_reg <= retired_reg + 32'd1;
        end
    end

    always_comb begin
        state_next = state_reg;
        stat_next  = stat_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) state_next = S_FETCH;
            end
            S_FETCH: begin
                if (imem_error) begin
                    state_next = S_HALT;
                    stat_next  = STAT_ADR;
                end else if (imem_ack) begin
                    state_next = S_DECODE;
                end else if (wd_expired) begin
                    state_next = S_HALT;
                    stat_next  = STAT_ADR;
                end
            end
            S_DECODE: begin
                if (icode == IC_HALT) begin
                    state_next = S_HALT;
                    stat_next  = STAT_HLT;
                end else if (icode > IC_POPQ || !ifun_legal(icode, ifun)) begin
                    state_next = S_HALT;
                    stat_next  = STAT_INS;
                end else begin
                    state_next = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                if (needs_mem(icode_reg))     state_next = S_MEMORY;
                else if (needs_wb(icode_reg)) state_next = S_WRITEBACK;
                else                          state_next = S_PCUPD;
            end
            S_MEMORY: begin
                if (dmem_error) begin
                    state_next = S_HALT;
                    stat_next  = STAT_ADR;
                end else if (dmem_ack) begin
                    state_next = (icode_reg == IC_RMMOVQ) ? S_PCUPD : S_WRITEBACK;
                end else if (wd_expired) begin
                    state_next = S_HALT;
                    stat_next  = STAT_ADR;
                end
            end
            S_WRITEBACK: state_next = S_PCUPD;
            S_PCUPD:     state_next = S_FETCH;
            S_HALT:      state_next = S_HALT;
            default:     state_next = S_IDLE;
        endcase
    end

    // Outputs decode straight from the state register so reset drops them at once.
    always_comb begin
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        decode_en  = 1'b0;
        execute_en = 1'b0;
        wb_en      = 1'b0;
        pc_en      = 1'b0;
        busy       = 1'b1;
        case (state_reg)
            S_IDLE:      busy       = 1'b0;
            S_FETCH:     imem_req   = 1'b1;
            S_DECODE:    decode_en  = 1'b1;
            S_EXECUTE:   execute_en = 1'b1;
            S_MEMORY:    dmem_req   = 1'b1;
            S_WRITEBACK: wb_en      = 1'b1;
            S_PCUPD:     pc_en      = 1'b1;
            S_HALT:      busy       = 1'b0;
            default:     busy       = 1'b0;
        endcase
    end

    assign stat    = stat_reg;
    assign retired = retired_reg;

endmodule

// File: tb/tb_seq_stage_ctrl.sv
// Directed, table-driven bench for seq_stage_ctrl: each record is one
// instruction with its memory wait/error behaviour and expected stage trace.
module tb_seq_stage_ctrl;

    localparam logic [2:0] AOK = 3'd1;
    localparam logic [2:0] HLT = 3'd2;
    localparam logic [2:0] ADR = 3'd3;
    localparam logic [2:0] INS = 3'd4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  icode = 4'h0;
    logic [3:0]  ifun = 4'h0;
    logic        imem_ack = 1'b0;
    logic        imem_error = 1'b0;
    logic        dmem_ack = 1'b0;
    logic        dmem_error = 1'b0;
    logic        imem_req, dmem_req, decode_en, execute_en, wb_en, pc_en, busy;
    logic [2:0]  stat;
    logic [31:0] retired;

    seq_stage_ctrl #(.MEM_TIMEOUT(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .icode      (icode),
        .ifun       (ifun),
        .imem_ack   (imem_ack),
        .imem_error (imem_error),
        .dmem_ack   (dmem_ack),
        .dmem_error (dmem_error),
        .imem_req   (imem_req),
        .dmem_req   (dmem_req),
        .decode_en  (decode_en),
        .execute_en (execute_en),
        .wb_en      (wb_en),
        .pc_en      (pc_en),
        .stat       (stat),
        .busy       (busy),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    // Stage codes in the trace: F=1 D=2 E=3 M=4 W=5 P=6.
    typedef struct {
        logic [3:0]  ic;
        logic [3:0]  fn;
        int          iwait;
        int          dwait;
        bit          ierr;
        bit          derr;
        int          cycles;
        logic [63:0] seq;
        logic [2:0]  st;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   exp_ret = 0;
    bit   halted = 1'b1;
    vec_t vecs[24];

    function automatic vec_t mk(input logic [3:0] ic, input logic [3:0] fn,
                                input int iw, input int dw, input bit ie, input bit de,
                                input int cyc, input logic [63:0] sq, input logic [2:0] st);
        vec_t v;
        v.ic = ic; v.fn = fn; v.iwait = iw; v.dwait = dw; v.ierr = ie; v.derr = de;
        v.cycles = cyc; v.seq = sq; v.st = st;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic reset_and_start();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        check("reset_outputs", {imem_req, dmem_req, decode_en, execute_en, wb_en, pc_en, busy}, 7'b0);
        check("reset_stat", stat, AOK);
        check("reset_retired", retired, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 1'b0);
        start = 1'b1;
        @(negedge clk);
        check("start_fetch", imem_req, 1'b1);
        exp_ret = 0;
        halted  = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int          cycles = 0;
        int          iw = 0;
        int          dw = 0;
        logic [63:0] seq = 64'd0;
        logic [3:0]  code;
        bit          last_pc;
        int          quiet = 0;
        logic [2:0]  stat_at_halt;
        if (halted) reset_and_start();
        icode = v.ic;
        ifun  = v.fn;
        while (busy) begin
            code = imem_req ? 4'd1 : decode_en ? 4'd2 : execute_en ? 4'd3 :
                   dmem_req ? 4'd4 : wb_en ? 4'd5 : pc_en ? 4'd6 : 4'hF;
            seq = (seq << 4) | 64'(code);
            cycles++;
            imem_ack = 1'b0; imem_error = 1'b0; dmem_ack = 1'b0; dmem_error = 1'b0;
            if (imem_req) begin
                if (iw == v.iwait) begin imem_ack = 1'b1; imem_error = v.ierr; end
                iw++;
            end
            if (dmem_req) begin
                if (dw == v.dwait) begin dmem_ack = 1'b1; dmem_error = v.derr; end
                dw++;
            end
            last_pc = pc_en;
            @(negedge clk);
            if (last_pc || cycles >= 40) break;
        end
        imem_ack = 1'b0; imem_error = 1'b0; dmem_ack = 1'b0; dmem_error = 1'b0;
        if (v.st == AOK) exp_ret++;
        $display("vec %0d icode=%h ifun=%h cycles=%0d trace=%0h stat=%0d retired=%0d",
                 idx, v.ic, v.fn, cycles, seq, stat, retired);
        check($sformatf("v%0d_cycles", idx), 64'(cycles), 64'(v.cycles));
        check($sformatf("v%0d_trace", idx), seq, v.seq);
        check($sformatf("v%0d_stat", idx), stat, v.st);
        check($sformatf("v%0d_retired", idx), retired, 32'(exp_ret));
        check($sformatf("v%0d_busy", idx), busy, v.st == AOK);
        if (v.st != AOK) begin
            stat_at_halt = stat;
            repeat (3) begin
                if (imem_req | dmem_req | decode_en | execute_en | wb_en | pc_en) quiet++;
                @(negedge clk);
            end
            check($sformatf("v%0d_halt_quiet", idx), 64'(quiet), 64'd0);
            check($sformatf("v%0d_halt_stat_frozen", idx), stat, stat_at_halt);
            halted = 1'b1;
        end
    endtask

    initial begin
        int n;
        vecs[0]  = mk(4'h6, 4'h0, 0, 0, 0, 0, 5, 64'h12356,     AOK);
        vecs[1]  = mk(4'h0, 4'h0, 0, 0, 0, 0, 2, 64'h12,        HLT);
        vecs[2]  = mk(4'h5, 4'h0, 0, 3, 0, 0, 9, 64'h123444456, AOK);
        vecs[3]  = mk(4'h0, 4'h0, 0, 0, 0, 0, 2, 64'h12,        HLT);
        vecs[4]  = mk(4'h1, 4'h0, 0, 0, 0, 0, 4, 64'h1236,      AOK);
        vecs[5]  = mk(4'h7, 4'h3, 0, 0, 0, 0, 4, 64'h1236,      AOK);
        vecs[6]  = mk(4'h7, 4'h6, 0, 0, 0, 0, 4, 64'h1236,      AOK);
        vecs[7]  = mk(4'h2, 4'h1, 0, 0, 0, 0, 5, 64'h12356,     AOK);
        vecs[8]  = mk(4'h3, 4'h0, 0, 0, 0, 0, 5, 64'h12356,     AOK);
        vecs[9]  = mk(4'h4, 4'h0, 0, 0, 0, 0, 5, 64'h12346,     AOK);
        vecs[10] = mk(4'h8, 4'h0, 2, 0, 0, 0, 8, 64'h11123456,  AOK);
        vecs[11] = mk(4'h9, 4'h0, 0, 0, 0, 0, 6, 64'h123456,    AOK);
        vecs[12] = mk(4'hA, 4'h0, 0, 0, 0, 0, 6, 64'h123456,    AOK);
        vecs[13] = mk(4'hB, 4'h0, 1, 1, 0, 0, 8, 64'h11234456,  AOK);
        vecs[14] = mk(4'h6, 4'h3, 0, 0, 0, 0, 5, 64'h12356,     AOK);
        vecs[15] = mk(4'h4, 4'h0, 0, 2, 0, 0, 7, 64'h1234446,   AOK);
        vecs[16] = mk(4'hC, 4'h0, 0, 0, 0, 0, 2, 64'h12,        INS);
        vecs[17] = mk(4'h6, 4'h4, 0, 0, 0, 0, 2, 64'h12,        INS);
        vecs[18] = mk(4'h2, 4'h7, 0, 0, 0, 0, 2, 64'h12,        INS);
        vecs[19] = mk(4'h1, 4'h1, 0, 0, 0, 0, 2, 64'h12,        INS);
        vecs[20] = mk(4'h4, 4'h1, 0, 0, 0, 0, 2, 64'h12,        INS);
        vecs[21] = mk(4'hF, 4'h0, 0, 0, 0, 0, 2, 64'h12,        INS);
        vecs[22] = mk(4'hA, 4'h0, 0, 0, 0, 1, 4, 64'h1234,      ADR);
        vecs[23] = mk(4'h5, 4'h0, 1, 0, 1, 0, 2, 64'h11,        ADR);

        for (int i = 0; i < 24; i++) run_vec(vecs[i], i);

        // Fetch that is never acknowledged must be abandoned after 16 request cycles.
        reset_and_start();
        icode = 4'h6; ifun = 4'h0;
        n = 0;
        while (imem_req && n < 40) begin
            n++;
            @(negedge clk);
        end
        $display("timeout imem_req_cycles=%0d stat=%0d busy=%0d", n, stat, busy);
        check("timeout_cycles", 64'(n), 64'd16);
        check("timeout_stat", stat, ADR);
        check("timeout_busy", busy, 1'b0);
        check("timeout_retired", retired, 32'd0);
        halted = 1'b1;

        // Reset during a stalled MEMORY stage, then a clean restart.
        reset_and_start();
        icode = 4'h5; ifun = 4'h0;
        n = 0;
        while (!dmem_req && n < 20) begin
            imem_ack = imem_req;
            @(negedge clk);
            n++;
        end
        imem_ack = 1'b0;
        check("midmem_reached", dmem_req, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        $display("midmem_reset dmem_req=%0d busy=%0d stat=%0d", dmem_req, busy, stat);
        check("midmem_dmem_req_drop", dmem_req, 1'b0);
        check("midmem_idle", {busy, wb_en, pc_en}, 3'b0);
        halted = 1'b1;
        run_vec(vecs[0], 100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
